// File: rtl/imem_loader.sv
// Instruction memory loader: packs a byte stream into 32-bit words, writes them
// to consecutive word addresses and holds the core stalled until the load ends.
module imem_loader #(
  parameter int unsigned ADDRW      = 5,
  parameter bit          BIG_ENDIAN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic             we,
  output logic [ADDRW-1:0] waddr,
  output logic [31:0]      wdata,
  output logic             cpu_stall,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [ADDRW-2:0] words
);

  localparam int unsigned WORDW = ADDRW - 1;
  localparam logic [ADDRW-1:0] LAST_ADDR = {{(ADDRW-2){1'b1}}, 2'b00};

  typedef enum logic [1:0] {IDLE, RECV, WRITE, FINISH} state_e;

  state_e           state_q, state_d;
  logic [ADDRW-1:0] addr_q, addr_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [31:0]      asm_q, asm_d;
  logic             last_q, last_d;
  logic             err_q, err_d;
  logic [WORDW-1:0] words_q, words_d;
  logic             in_ready_q, in_ready_d;
  logic             we_q, we_d;
  logic [ADDRW-1:0] waddr_q, waddr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             cpu_stall_q, cpu_stall_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [1:0]       lane;

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    asm_d   = asm_q;
    last_d  = last_q;
    err_d   = err_q;
    words_d = words_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    lane    = BIG_ENDIAN ? (2'd3 - cnt_q) : cnt_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RECV;
          addr_d  = '0;
          cnt_d   = '0;
          asm_d   = '0;
          last_d  = 1'b0;
          err_d   = 1'b0;
          words_d = '0;
        end
      end
      RECV: begin
        if (in_valid && in_ready_q) begin
          asm_d[{lane, 3'b000} +: 8] = in_data;
          cnt_d  = cnt_q + 2'd1;
          last_d = in_last;
          if (cnt_q == 2'd3 || in_last) begin
            state_d = WRITE;
            waddr_d = addr_q;
            wdata_d = asm_d;
            if (in_last && cnt_q != 2'd3) err_d = 1'b1;
          end
        end
      end
      WRITE: begin
        asm_d   = '0;
        cnt_d   = '0;
        words_d = words_q + WORDW'(1);
        // The final slot never advances addr, so a load cannot wrap onto word 0
        if (addr_q == LAST_ADDR) begin
          state_d = FINISH;
          if (!last_q) err_d = 1'b1;
        end else begin
          addr_d  = addr_q + ADDRW'(4);
          state_d = last_q ? FINISH : RECV;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == RECV);
    we_d        = (state_d == WRITE);
    cpu_stall_d = (state_d == RECV) || (state_d == WRITE);
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == FINISH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      cnt_q       <= '0;
      asm_q       <= '0;
      last_q      <= 1'b0;
      err_q       <= 1'b0;
      words_q     <= '0;
      in_ready_q  <= 1'b0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      cpu_stall_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      asm_q       <= asm_d;
      last_q      <= last_d;
      err_q       <= err_d;
      words_q     <= words_d;
      in_ready_q  <= in_ready_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      cpu_stall_q <= cpu_stall_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign we        = we_q;
  assign waddr     = waddr_q;
  assign wdata     = wdata_q;
  assign cpu_stall = cpu_stall_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign words     = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: one big-endian and one little-endian instance
// share stimulus; writes and done pulses are logged and checked per scenario.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n, start, in_valid, in_last;
  logic [7:0]  in_data;

  logic        in_ready_be, we_be, cpu_stall_be, busy_be, done_be, err_be;
  logic [4:0]  waddr_be;
  logic [31:0] wdata_be;
  logic [3:0]  words_be;
  logic        in_ready_le, we_le, cpu_stall_le, busy_le, done_le, err_le;
  logic [4:0]  waddr_le;
  logic [31:0] wdata_le;
  logic [3:0]  words_le;

  imem_loader #(.ADDRW(5), .BIG_ENDIAN(1'b1)) dut_be (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready_be), .we(we_be), .waddr(waddr_be),
    .wdata(wdata_be), .cpu_stall(cpu_stall_be), .busy(busy_be), .done(done_be),
    .err(err_be), .words(words_be));

  imem_loader #(.ADDRW(5), .BIG_ENDIAN(1'b0)) dut_le (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready_le), .we(we_le), .waddr(waddr_le),
    .wdata(wdata_le), .cpu_stall(cpu_stall_le), .busy(busy_le), .done(done_le),
    .err(err_le), .words(words_le));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int errors  = 0;
  int gap_bad = 0;
  logic [7:0]  bytes [64];

  logic [4:0]  wa_be [$];
  logic [31:0] wd_be [$];
  int          wc_be [$];
  logic [4:0]  wa_le [$];
  logic [31:0] wd_le [$];
  int done_cnt = 0;
  int done_cyc = -1;

  always @(negedge clk) begin
    if (we_be) begin
      wa_be.push_back(waddr_be);
      wd_be.push_back(wdata_be);
      wc_be.push_back(cyc);
    end
    if (we_le) begin
      wa_le.push_back(waddr_le);
      wd_le.push_back(wdata_le);
    end
    if (done_be) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic clear_logs();
    wa_be.delete(); wd_be.delete(); wc_be.delete();
    wa_le.delete(); wd_le.delete();
  endtask

  // start arrives together with a junk byte that must not be taken
  task automatic begin_load();
    @(negedge clk);
    start = 1'b1; in_valid = 1'b1; in_data = 8'hEE; in_last = 1'b1;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic stream(input int n, input int last_idx, input bit gaps,
                        input int start_at, input int stop_after,
                        output int acc, output int last_cyc);
    int i = 0;
    int budget = 0;
    int d0 = done_cnt;
    bit st_done = 1'b0;
    last_cyc = -1;
    while (done_cnt == d0 && budget < 300 && !(stop_after >= 0 && i >= stop_after)) begin
      @(negedge clk);
      budget++;
      start = (start_at >= 0 && i == start_at && !st_done);
      if (start) st_done = 1'b1;
      if (gaps && (cyc % 2) == 1 && i < n && (i % 4) != 0 && !in_ready_be) gap_bad++;
      in_valid = in_ready_be && (i < n) && !(gaps && (cyc % 2) == 1);
      in_data  = bytes[i];
      in_last  = in_valid && (i == last_idx);
      if (in_valid) begin
        last_cyc = cyc;
        i++;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_last = 1'b0; start = 1'b0;
    acc = i;
    vectors++;
    if (stop_after < 0 && done_cnt == d0) begin
      errors++;
      $display("FAIL stream_done_timeout got no done within %0d cycles", budget);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
    #12;
    vectors++;
    if ({in_ready_be, we_be, waddr_be, wdata_be, cpu_stall_be, busy_be, done_be, err_be, words_be} !== '0) begin
      errors++;
      $display("FAIL reset_be got rdy=%b we=%b a=%h d=%h st=%b b=%b dn=%b e=%b w=%0d exp all 0",
               in_ready_be, we_be, waddr_be, wdata_be, cpu_stall_be, busy_be, done_be, err_be, words_be);
    end
    vectors++;
    if ({in_ready_le, we_le, waddr_le, wdata_le, cpu_stall_le, busy_le, done_le, err_le, words_le} !== '0) begin
      errors++;
      $display("FAIL reset_le got nonzero outputs, exp all 0");
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (busy_be !== 1'b0 || in_ready_be !== 1'b0) begin
      errors++;
      $display("FAIL idle_wait got busy=%b rdy=%b exp 0 0", busy_be, in_ready_be);
    end
  endtask

  task automatic test_basic(input bit gaps);
    int acc, lc, d0;
    bytes[0] = 8'h12; bytes[1] = 8'h34; bytes[2] = 8'h56; bytes[3] = 8'h78;
    bytes[4] = 8'h9A; bytes[5] = 8'hBC; bytes[6] = 8'hDE; bytes[7] = 8'hF0;
    clear_logs();
    gap_bad = 0;
    d0 = done_cnt;
    begin_load();
    vectors++;
    if (busy_be !== 1'b1 || cpu_stall_be !== 1'b1 || in_ready_be !== 1'b1) begin
      errors++;
      $display("FAIL recv_flags got busy=%b stall=%b rdy=%b exp 1 1 1", busy_be, cpu_stall_be, in_ready_be);
    end
    stream(8, 7, gaps, -1, -1, acc, lc);
    vectors++;
    if (wa_be.size() != 2) begin
      errors++;
      $display("FAIL basic_wcount got %0d exp 2", wa_be.size());
    end else begin
      vectors++;
      if (wa_be[0] !== 5'd0 || wd_be[0] !== 32'h12345678) begin
        errors++;
        $display("FAIL basic_w0 got (%h,%h) exp (00,12345678)", wa_be[0], wd_be[0]);
      end
      vectors++;
      if (wa_be[1] !== 5'd4 || wd_be[1] !== 32'h9ABCDEF0) begin
        errors++;
        $display("FAIL basic_w1 got (%h,%h) exp (04,9abcdef0)", wa_be[1], wd_be[1]);
      end
      vectors++;
      if (wc_be[1] - lc != 1 || done_cyc - lc != 2) begin
        errors++;
        $display("FAIL basic_latency got we=+%0d done=+%0d exp +1 +2", wc_be[1] - lc, done_cyc - lc);
      end
    end
    vectors++;
    if (done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL basic_done_pulses got %0d exp 1", done_cnt - d0);
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (words_be !== 4'd2 || err_be !== 1'b0 || busy_be !== 1'b0 || cpu_stall_be !== 1'b0) begin
      errors++;
      $display("FAIL basic_final got words=%0d err=%b busy=%b stall=%b exp 2 0 0 0",
               words_be, err_be, busy_be, cpu_stall_be);
    end
    if (gaps) begin
      vectors++;
      if (gap_bad != 0) begin
        errors++;
        $display("FAIL gap_ready got %0d low cycles exp 0", gap_bad);
      end
    end
  endtask

  task automatic test_short_word();
    int acc, lc, d0;
    bytes[0] = 8'hAA; bytes[1] = 8'hBB;
    clear_logs();
    d0 = done_cnt;
    begin_load();
    stream(2, 1, 1'b0, -1, -1, acc, lc);
    repeat (2) @(negedge clk);
    vectors++;
    if (wa_be.size() != 1 || wd_be[0] !== 32'hAABB0000 || wa_be[0] !== 5'd0) begin
      errors++;
      $display("FAIL short_write got n=%0d data=%h exp n=1 (00,aabb0000)", wa_be.size(), wd_be[0]);
    end
    vectors++;
    if (err_be !== 1'b1 || words_be !== 4'd1 || done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL short_status got err=%b words=%0d done=%0d exp 1 1 1", err_be, words_be, done_cnt - d0);
    end
  endtask

  task automatic test_capacity();
    int acc, lc;
    logic [31:0] exp_w;
    for (int i = 0; i < 36; i++) bytes[i] = 8'(i + 1);
    clear_logs();
    begin_load();
    stream(36, -1, 1'b0, -1, -1, acc, lc);
    repeat (4) @(negedge clk);
    vectors++;
    if (acc != 32 || wa_be.size() != 8) begin
      errors++;
      $display("FAIL cap_count got bytes=%0d writes=%0d exp 32 8", acc, wa_be.size());
    end else begin
      for (int w = 0; w < 8; w++) begin
        exp_w = {8'(4*w + 1), 8'(4*w + 2), 8'(4*w + 3), 8'(4*w + 4)};
        vectors++;
        if (wa_be[w] !== 5'(4*w) || wd_be[w] !== exp_w) begin
          errors++;
          $display("FAIL cap_w%0d got (%h,%h) exp (%h,%h)", w, wa_be[w], wd_be[w], 5'(4*w), exp_w);
        end
      end
    end
    vectors++;
    if (err_be !== 1'b1 || words_be !== 4'd8 || in_ready_be !== 1'b0) begin
      errors++;
      $display("FAIL cap_status got err=%b words=%0d rdy=%b exp 1 8 0", err_be, words_be, in_ready_be);
    end
  endtask

  task automatic test_reset_midload();
    int acc, lc, d0;
    bytes[0] = 8'h11; bytes[1] = 8'h22;
    clear_logs();
    begin_load();
    stream(4, -1, 1'b0, -1, 2, acc, lc);
    d0 = done_cnt;
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (busy_be !== 1'b0 || cpu_stall_be !== 1'b0 || in_ready_be !== 1'b0 || we_be !== 1'b0) begin
      errors++;
      $display("FAIL midreset_async got busy=%b stall=%b rdy=%b we=%b exp 0 0 0 0",
               busy_be, cpu_stall_be, in_ready_be, we_be);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (wa_be.size() != 0 || done_cnt != d0 || busy_be !== 1'b0) begin
      errors++;
      $display("FAIL midreset_quiet got writes=%0d done=%0d busy=%b exp 0 0 0", wa_be.size(), done_cnt - d0, busy_be);
    end
    bytes[0] = 8'hAA; bytes[1] = 8'hBB; bytes[2] = 8'hCC; bytes[3] = 8'hDD;
    begin_load();
    stream(4, 3, 1'b0, -1, -1, acc, lc);
    vectors++;
    if (wa_be.size() != 1 || wa_be[0] !== 5'd0 || wd_be[0] !== 32'hAABBCCDD) begin
      errors++;
      $display("FAIL midreset_reload got n=%0d (%h,%h) exp n=1 (00,aabbccdd)", wa_be.size(), wa_be[0], wd_be[0]);
    end
  endtask

  task automatic test_little_endian();
    int acc, lc, d0;
    bytes[0] = 8'h12; bytes[1] = 8'h34; bytes[2] = 8'h56; bytes[3] = 8'h78;
    clear_logs();
    d0 = done_cnt;
    begin_load();
    stream(4, 3, 1'b0, 2, -1, acc, lc);
    repeat (2) @(negedge clk);
    vectors++;
    if (wa_le.size() != 1 || wa_le[0] !== 5'd0 || wd_le[0] !== 32'h78563412) begin
      errors++;
      $display("FAIL le_write got n=%0d (%h,%h) exp n=1 (00,78563412)", wa_le.size(), wa_le[0], wd_le[0]);
    end
    vectors++;
    if (wd_be.size() != 1 || wd_be[0] !== 32'h12345678) begin
      errors++;
      $display("FAIL be_same_stream got %h exp 12345678", wd_be[0]);
    end
    vectors++;
    if (err_le !== 1'b0 || words_le !== 4'd1 || done_cnt - d0 != 1 || busy_le !== 1'b0) begin
      errors++;
      $display("FAIL le_status got err=%b words=%0d done=%0d busy=%b exp 0 1 1 0",
               err_le, words_le, done_cnt - d0, busy_le);
    end
  endtask

  initial begin
    test_reset();
    test_basic(1'b0);
    test_basic(1'b1);
    test_short_word();
    test_capacity();
    test_reset_midload();
    test_little_endian();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
